// File: rtl/door_pkg.sv
// Shared types and helpers for the garage-door plant model.
package door_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FAULT   = 2'd3
  } door_state_e;

  // Limit-switch encoding {Up_max, Dn_max}
  localparam logic [1:0] LIM_FAULT  = 2'b11;
  localparam logic [1:0] LIM_OPEN   = 2'b10;
  localparam logic [1:0] LIM_CLOSED = 2'b01;

  // Bits needed to hold positions 0..pos_max
  function automatic int unsigned POS_W(input int unsigned pos_max);
    int unsigned w;
    w = 1;
    while ((longint'(1) << w) <= longint'(pos_max)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the clock into motor steps: one step every STEP_DIV running cycles.
// run=0 holds the count, restart clears it to begin a fresh full period.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic step
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/door_plant_model.sv
// Garage door mechanism: motor-driven position counter with limit switches.
// Optional obstacle stall during closing enabled by DOOR_PLANT_OBSTACLE_EN.
module door_plant_model
  import door_pkg::*;
#(
  parameter int unsigned POS_MAX   = 15,
  parameter int unsigned STEP_DIV  = 4,
  parameter int unsigned INIT_OPEN = 0
) (
  input  logic                        clock,
  input  logic                        reset,
`ifdef DOOR_PLANT_OBSTACLE_EN
  input  logic                        obstacle,
`endif
  input  logic                        Up_motor,
  input  logic                        Dn_motor,
  output logic                        Up_max,
  output logic                        Dn_max,
  output logic [POS_W(POS_MAX)-1:0]   position,
  output logic                        moving,
  output logic                        over_travel,
  output logic                        fault
);

  localparam int unsigned PW = POS_W(POS_MAX);
  localparam logic [PW-1:0] POS_TOP  = PW'(POS_MAX);
  localparam logic [PW-1:0] POS_INIT = (INIT_OPEN != 0) ? POS_TOP : '0;

  door_state_e   state_q, state_d;
  logic [PW-1:0] position_q, position_d;
  logic          over_travel_q, over_travel_d;
  logic          moving_c, stall_c, run_c, restart_c, step_c;
  logic [1:0]    lim_c;

`ifdef DOOR_PLANT_OBSTACLE_EN
  assign stall_c = obstacle && (state_q == CLOSING);
`else
  assign stall_c = 1'b0;
`endif

  // Next state from the motor commands; FAULT only leaves through reset
  always_comb begin
    state_d = state_q;
    if (state_q != FAULT) begin
      unique case ({Up_motor, Dn_motor})
        2'b11:   state_d = FAULT;
        2'b10:   state_d = OPENING;
        2'b01:   state_d = CLOSING;
        default: state_d = STOPPED;
      endcase
    end
  end

  assign moving_c  = (state_q == OPENING) || (state_q == CLOSING);
  assign run_c     = moving_c && !stall_c;
  assign restart_c = (state_d != state_q) || !moving_c;

  step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .run     (run_c),
    .restart (restart_c),
    .step    (step_c)
  );

  // Saturating position update; a step into a limit reports over-travel
  always_comb begin
    position_d    = position_q;
    over_travel_d = 1'b0;
    if (step_c) begin
      if (state_q == OPENING) begin
        if (position_q < POS_TOP) position_d = position_q + PW'(1);
        else                      over_travel_d = 1'b1;
      end else if (state_q == CLOSING) begin
        if (position_q != '0) position_d = position_q - PW'(1);
        else                  over_travel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= STOPPED;
      position_q    <= POS_INIT;
      over_travel_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      position_q    <= position_d;
      over_travel_q <= over_travel_d;
    end
  end

  // Limit decode; FAULT forces the illegal both-limits pattern
  always_comb begin
    lim_c = 2'b00;
    if (state_q == FAULT)           lim_c = LIM_FAULT;
    else if (position_q == POS_TOP) lim_c = LIM_OPEN;
    else if (position_q == '0)      lim_c = LIM_CLOSED;
  end

  assign Up_max      = lim_c[1];
  assign Dn_max      = lim_c[0];
  assign position    = position_q;
  assign moving      = moving_c;
  assign over_travel = over_travel_q;
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_door_plant_model.sv
// Directed self-checking bench for door_plant_model (POS_MAX=15, STEP_DIV=4, closed at reset).
module tb_door_plant_model;

  logic       clock;
  logic       reset;
  logic       Up_motor;
  logic       Dn_motor;
  logic       Up_max;
  logic       Dn_max;
  logic [3:0] position;
  logic       moving;
  logic       over_travel;
  logic       fault;

  int unsigned n_checks;
  int unsigned n_fail;

  door_plant_model #(
    .POS_MAX   (15),
    .STEP_DIV  (4),
    .INIT_OPEN (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .Up_motor    (Up_motor),
    .Dn_motor    (Dn_motor),
    .Up_max      (Up_max),
    .Dn_max      (Dn_max),
    .position    (position),
    .moving      (moving),
    .over_travel (over_travel),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    Up_motor = 1'b0;
    Dn_motor = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    Up_motor = 1'b0;
    Dn_motor = 1'b0;

    // Reset state: closed
    do_reset();
    check("rst_pos", position, 0);
    check("rst_dn_max", Dn_max, 1);
    check("rst_up_max", Up_max, 0);
    check("rst_moving", moving, 0);
    check("rst_fault", fault, 0);
    check("rst_over_travel", over_travel, 0);

    // Full opening run; edge N is the first edge sampling Up_motor=1
    Up_motor = 1'b1;
    tick(1);
    check("open_moving", moving, 1);
    check("open_pos_n0", position, 0);
    tick(3);
    check("open_pos_n3", position, 0);
    tick(1);
    check("open_pos_n4", position, 1);
    check("open_dn_max_off", Dn_max, 0);
    tick(55);
    check("open_pos_n59", position, 14);
    check("open_up_max_n59", Up_max, 0);
    tick(1);
    check("open_pos_n60", position, 15);
    check("open_up_max_n60", Up_max, 1);
    check("open_ot_n60", over_travel, 0);
    tick(3);
    check("open_ot_n63", over_travel, 0);
    tick(1);
    check("open_ot_n64", over_travel, 1);
    check("open_pos_n64", position, 15);
    check("open_moving_stalled", moving, 1);
    tick(1);
    check("open_ot_n65", over_travel, 0);
    tick(3);
    check("open_ot_n68", over_travel, 1);

    // Stop at 7, pause, then close: first decrement 4 edges after Dn sampled
    do_reset();
    Up_motor = 1'b1;
    tick(29);
    check("mid_pos7", position, 7);
    Up_motor = 1'b0;
    tick(1);
    check("mid_stop_moving", moving, 0);
    tick(2);
    check("mid_hold_pos", position, 7);
    Dn_motor = 1'b1;
    tick(1);
    check("mid_close_moving", moving, 1);
    tick(3);
    check("mid_close_pos_d3", position, 7);
    tick(1);
    check("mid_close_pos_d4", position, 6);
    Dn_motor = 1'b0;
    tick(1);
    check("mid_close_stop", moving, 0);

    // Closing at the bottom limit only reports over-travel
    do_reset();
    Dn_motor = 1'b1;
    tick(4);
    check("bot_ot_d3", over_travel, 0);
    tick(1);
    check("bot_ot_d4", over_travel, 1);
    check("bot_pos", position, 0);
    check("bot_dn_max", Dn_max, 1);
    tick(1);
    check("bot_ot_d5", over_travel, 0);
    Dn_motor = 1'b0;

    // Up toggled every 2 cycles never completes a step period
    do_reset();
    for (int i = 0; i < 10; i++) begin
      Up_motor = 1'b1;
      tick(2);
      Up_motor = 1'b0;
      tick(2);
    end
    check("toggle_pos", position, 0);
    check("toggle_ot", over_travel, 0);

    // Both motors for one cycle mid-travel: sticky fault
    do_reset();
    Up_motor = 1'b1;
    tick(22);
    check("flt_pre_pos", position, 5);
    Dn_motor = 1'b1;
    tick(1);
    Up_motor = 1'b0;
    Dn_motor = 1'b0;
    check("flt_fault", fault, 1);
    check("flt_up_max", Up_max, 1);
    check("flt_dn_max", Dn_max, 1);
    check("flt_moving", moving, 0);
    tick(5);
    Up_motor = 1'b1;
    tick(10);
    check("flt_sticky_up", fault, 1);
    check("flt_pos_frozen", position, 5);
    Up_motor = 1'b0;
    Dn_motor = 1'b1;
    tick(6);
    check("flt_sticky_dn", fault, 1);
    check("flt_pos_frozen2", position, 5);
    Dn_motor = 1'b0;
    reset = 1'b0;
    tick(1);
    check("flt_clr_fault", fault, 0);
    check("flt_clr_pos", position, 0);
    check("flt_clr_up_max", Up_max, 0);
    check("flt_clr_dn_max", Dn_max, 1);
    reset = 1'b1;

    // Reset mid-travel discards the partial step
    Up_motor = 1'b1;
    tick(14);
    check("rmid_pre_pos", position, 3);
    reset = 1'b0;
    tick(1);
    check("rmid_pos", position, 0);
    check("rmid_moving", moving, 0);
    reset = 1'b1;
    tick(4);
    check("rmid_restart_n3", position, 0);
    tick(1);
    check("rmid_restart_n4", position, 1);
    Up_motor = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
